// File: rtl/fp_norm_round_pipe.sv
// Two-stage post-add normalise/round for the FP adder: stage 1 normalises, stage 2 rounds and saturates.
// Optional NORM_FLAGS_EN builds the {overflow, underflow, inexact} flag path; otherwise flagsOut is 0.
module fp_norm_round_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [MAN_W+1:0]       mantIn,
   input  logic [2:0]             grsIn,
   input  logic [EXP_W-1:0]       expIn,
   input  logic                   signIn,
   input  logic [1:0]             rndMode,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [EXP_W+MAN_W:0]   resultOut,
   output logic [2:0]             flagsOut
);

   localparam int EW2 = EXP_W + 2;
   localparam int LZW = $clog2(MAN_W + 2);
   localparam int WW  = MAN_W + 3;

   typedef logic signed [EW2-1:0] sexp_t;

   localparam sexp_t EXP_INF = sexp_t'((2 ** EXP_W) - 1);

   // Handshake
   logic s1Valid, s2Valid;
   logic advS1, advS2;

   assign advS2    = !s2Valid || outReady;
   assign advS1    = !s1Valid || advS2;
   assign inReady  = advS1;
   assign outValid = s2Valid;

   // Stage 1: normalise
   logic [LZW-1:0] lzCnt;
   logic [WW-1:0]  shWord;
   logic [MAN_W:0] n1Mant;
   logic           n1G, n1R, n1S, n1Zero;
   sexp_t          n1Exp;

   always_comb begin
      lzCnt = LZW'(MAN_W + 1);
      for (int i = 0; i <= MAN_W; i++)
         if (mantIn[i]) lzCnt = LZW'(MAN_W - i);
      // G then R slide into the vacated LSBs; sticky is never shifted up
      shWord = {mantIn[MAN_W:0], grsIn[2], grsIn[1]} << lzCnt;
      n1Zero = (mantIn == '0) && (grsIn == 3'b000);
      if (mantIn[MAN_W+1]) begin
         n1Mant = mantIn[MAN_W+1:1];
         n1G    = mantIn[0];
         n1R    = grsIn[2];
         n1S    = grsIn[1] | grsIn[0];
         n1Exp  = sexp_t'({2'b00, expIn}) + sexp_t'(1);
      end else begin
         n1Mant = shWord[WW-1:2];
         n1G    = shWord[1];
         n1R    = shWord[0];
         n1S    = grsIn[0];
         n1Exp  = sexp_t'({2'b00, expIn}) - sexp_t'({{(EW2-LZW){1'b0}}, lzCnt});
      end
   end

   logic [MAN_W:0] s1Mant;
   logic           s1G, s1R, s1S, s1Zero, s1Sign;
   logic [1:0]     s1Mode;
   sexp_t          s1Exp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1Valid <= 1'b0;
         s1Mant  <= '0;
         s1G     <= 1'b0;
         s1R     <= 1'b0;
         s1S     <= 1'b0;
         s1Zero  <= 1'b0;
         s1Sign  <= 1'b0;
         s1Mode  <= 2'b00;
         s1Exp   <= '0;
      end else if (advS1) begin
         s1Valid <= inValid;
         if (inValid) begin
            s1Mant <= n1Mant;
            s1G    <= n1G;
            s1R    <= n1R;
            s1S    <= n1S;
            s1Zero <= n1Zero;
            s1Sign <= signIn;
            s1Mode <= rndMode;
            s1Exp  <= n1Exp;
         end
      end
   end

   // Stage 2: round, renormalise on carry, saturate
   logic                   inexact, incr, fracCarry, rndCarry, ovf, unf, toInf;
   logic [MAN_W-1:0]       rFrac;
   sexp_t                  rExp;
   logic [EXP_W+MAN_W:0]   n2Result;

   always_comb begin
      inexact = s1G | s1R | s1S;
      case (s1Mode)
         2'b00:   incr = s1G && (s1R || s1S || s1Mant[0]);
         2'b01:   incr = 1'b0;
         2'b10:   incr = inexact && !s1Sign;
         default: incr = inexact && s1Sign;
      endcase
      {fracCarry, rFrac} = {1'b0, s1Mant[MAN_W-1:0]} + MAN_W'(incr);
      // a fraction carry only bumps the exponent when it ripples past a set hidden bit
      rndCarry = fracCarry && s1Mant[MAN_W];
      rExp     = s1Exp + sexp_t'({{(EW2-1){1'b0}}, rndCarry});
      ovf      = (rExp >= EXP_INF);
      unf      = (rExp <= sexp_t'(0));
      toInf    = (s1Mode == 2'b00) || (s1Mode == 2'b10 && !s1Sign) ||
                 (s1Mode == 2'b11 && s1Sign);
      if (s1Zero)
         n2Result = {(s1Sign && s1Mode == 2'b11), {(EXP_W+MAN_W){1'b0}}};
      else if (ovf)
         n2Result = toInf ? {s1Sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                          : {s1Sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      else if (unf)
         n2Result = {s1Sign, {(EXP_W+MAN_W){1'b0}}};
      else
         n2Result = {s1Sign, rExp[EXP_W-1:0], rFrac};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2Valid   <= 1'b0;
         resultOut <= '0;
      end else if (advS2) begin
         s2Valid <= s1Valid;
         if (s1Valid) resultOut <= n2Result;
      end
   end

`ifdef NORM_FLAGS_EN
   logic [2:0] n2Flags, flagsReg;

   always_comb begin
      if (s1Zero)   n2Flags = 3'b000;
      else if (ovf) n2Flags = 3'b101;
      else if (unf) n2Flags = 3'b011;
      else          n2Flags = {2'b00, inexact};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 flagsReg <= 3'b000;
      else if (advS2 && s1Valid)  flagsReg <= n2Flags;
   end

   assign flagsOut = flagsReg;
`else
   assign flagsOut = 3'b000;
`endif

endmodule
